// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider (with helper module adder)
//  Description : Multi-cycle restoring divider for the Multiply-Division Unit.
//                Produces one quotient bit per clock. The trial subtraction
//                reuses the combinational adder: it is fed the inverted
//                divisor with carry_in = 1. Quotient, remainder and
//                div_by_zero are valid while done pulses for one cycle.
//                Optional build macro SEQ_DIVIDER_SIGNED_EN adds a signed_op
//                input and a FIX state. In that build every non-zero-divisor
//                operation takes one extra cycle.
//  Revision    : 1.0 - initial release
// ============================================================================

module adder #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b + {{(WIDTH-1){1'b0}}, carry_in};
endmodule

module seq_divider #(
    parameter int parallelism = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [parallelism-1:0] dividend,
    input  logic [parallelism-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic                   signed_op,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [parallelism-1:0] quotient,
    output logic [parallelism-1:0] remainder,
    output logic                   div_by_zero
);

    localparam int c_cnt_w = $clog2(parallelism);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [1:0] c_st_fix  = 2'd3;
    localparam logic [parallelism-1:0] c_one = parallelism'(1);
`endif

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [parallelism-1:0] r_q;
    logic [parallelism-1:0] r_r;
    logic [parallelism-1:0] r_dvs;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_dbz;

    logic                   w_accept;
    logic                   w_dvs_zero;
    logic [parallelism-1:0] w_dd_mag;
    logic [parallelism-1:0] w_dv_mag;
    logic [parallelism:0]   w_r_shift;
    logic [parallelism:0]   w_trial;

    assign w_accept   = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_dvs_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic w_dd_neg;
    logic w_dv_neg;
    logic r_neg_q;
    logic r_neg_r;

    // CALC always works on magnitudes. The sign fix-up happens in FIX.
    assign w_dd_neg = signed_op & dividend[parallelism-1];
    assign w_dv_neg = signed_op & divisor[parallelism-1];
    assign w_dd_mag = w_dd_neg ? (~dividend + c_one) : dividend;
    assign w_dv_mag = w_dv_neg ? (~divisor + c_one) : divisor;
`else
    assign w_dd_mag = dividend;
    assign w_dv_mag = divisor;
`endif

    // Shift the next dividend bit into the partial remainder. Then subtract
    // {0,divisor} as R' + ~{0,divisor} + 1.
    assign w_r_shift = {r_r, r_q[parallelism-1]};

    adder #(
        .WIDTH    (parallelism + 1)
    ) u_trial_sub (
        .a        (w_r_shift),
        .b        ({1'b1, ~r_dvs}),
        .carry_in (1'b1),
        .sum      (w_trial)
    );

    // Next-state selection. A divide by zero skips CALC entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next_state = w_dvs_zero ? c_st_done : c_st_calc;
                end
            end
            c_st_calc: begin
                if (r_cnt == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    w_next_state = c_st_fix;
`else
                    w_next_state = c_st_done;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            c_st_fix: begin
                w_next_state = c_st_done;
            end
`endif
            c_st_done: begin
                if (start) begin
                    w_next_state = w_dvs_zero ? c_st_done : c_st_calc;
                end else begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // State register plus status flags. The flags are registered from the
    // next state so that busy and done line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != c_st_idle);
            r_done  <= (w_next_state == c_st_done);
        end
    end

    // Datapath: load operands, run the restoring iterations and apply the
    // sign fix-up. The working registers double as the result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (w_accept) begin
            if (w_dvs_zero) begin
                r_q   <= '1;
                r_r   <= dividend;
                r_dbz <= 1'b1;
            end else begin
                r_q   <= w_dd_mag;
                r_r   <= '0;
                r_dvs <= w_dv_mag;
                r_cnt <= c_cnt_w'(parallelism - 1);
                r_dbz <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                r_neg_q <= w_dd_neg ^ w_dv_neg;
                r_neg_r <= w_dd_neg;
`endif
            end
        end else if (r_state == c_st_calc) begin
            // A non-negative trial difference means the divisor fits.
            // In that case keep the difference and record a 1.
            r_q   <= {r_q[parallelism-2:0], ~w_trial[parallelism]};
            r_r   <= w_trial[parallelism] ? w_r_shift[parallelism-1:0]
                                          : w_trial[parallelism-1:0];
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        else if (r_state == c_st_fix) begin
            r_q <= r_neg_q ? (~r_q + c_one) : r_q;
            r_r <= r_neg_r ? (~r_r + c_one) : r_r;
        end
`endif
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
